// File: rtl/clk_reconfig_sequencer.sv
// Purpose: gate -> drain -> apply -> settle -> stability-check -> ungate sequencer for RCD clock outputs.
// Latency: enable request with clk_stable high responds DRAIN_CYCLES+SETTLE_CYCLES+2 edges after acceptance.
// Backpressure: req_ready only in IDLE with pll_locked; one request in flight, one-cycle rsp_valid pulse.
// Ports: ref_clk/rst (sync, active-high); req_* request channel; pll_locked, clk_stable from the
//        distributor; cfg_* per-output configuration registers; rsp_* status pulse; busy = not IDLE.
module clk_reconfig_sequencer #(
    parameter int NUM_CLOCK_OUTPUTS = 8,
    parameter int IDX_W             = 3,
    parameter int DRAIN_CYCLES      = 4,
    parameter int SETTLE_CYCLES     = 16,
    parameter int STABLE_TIMEOUT    = 255
) (
    input  logic                           ref_clk,
    input  logic                           rst,
    input  logic                           pll_locked,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [IDX_W-1:0]               req_idx,
    input  logic                           req_enable,
    input  logic [3:0]                     req_div,
    input  logic [1:0]                     req_src,
    input  logic [NUM_CLOCK_OUTPUTS-1:0]   clk_stable,
    output logic [NUM_CLOCK_OUTPUTS-1:0]   cfg_clk_enable,
    output logic [NUM_CLOCK_OUTPUTS-1:0]   cfg_gate_enable,
    output logic [4*NUM_CLOCK_OUTPUTS-1:0] cfg_div_ratio,
    output logic [2*NUM_CLOCK_OUTPUTS-1:0] cfg_source_sel,
    output logic                           rsp_valid,
    output logic [1:0]                     rsp_status,
    output logic [IDX_W-1:0]               rsp_idx,
    output logic                           busy
);

    typedef enum logic [2:0] {IDLE, DRAIN, APPLY, SETTLE, CHECK, RESP} state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_BAD     = 2'b10;
    localparam logic [1:0] ST_PLL     = 2'b11;

    state_t                         state_q, state_d;
    logic [7:0]                     cnt_q, cnt_d;
    logic [IDX_W-1:0]               cap_idx_q, cap_idx_d;
    logic                           cap_en_q, cap_en_d;
    logic [3:0]                     cap_div_q, cap_div_d;
    logic [1:0]                     cap_src_q, cap_src_d;
    logic [NUM_CLOCK_OUTPUTS-1:0]   clk_en_d, gate_d;
    logic [4*NUM_CLOCK_OUTPUTS-1:0] div_d;
    logic [2*NUM_CLOCK_OUTPUTS-1:0] src_d;
    logic [1:0]                     status_d;
    logic [IDX_W-1:0]               rsp_idx_d;
    logic [NUM_CLOCK_OUTPUTS-1:0]   req_mask, tgt_mask;
    logic                           bad_req, pll_lost;

    function automatic logic [NUM_CLOCK_OUTPUTS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CLOCK_OUTPUTS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_CLOCK_OUTPUTS; i++) begin
            if (IDX_W'(i) == idx) m[i] = 1'b1;
        end
        return m;
    endfunction

    assign req_ready = (state_q == IDLE) && pll_locked;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign req_mask  = onehot(req_idx);
    assign tgt_mask  = onehot(cap_idx_q);
    assign bad_req   = (32'(req_idx) >= NUM_CLOCK_OUTPUTS) || (req_enable && req_src == 2'b11);
    assign pll_lost  = !pll_locked &&
                       (state_q == DRAIN || state_q == APPLY || state_q == SETTLE || state_q == CHECK);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_idx_d = cap_idx_q;
        cap_en_d  = cap_en_q;
        cap_div_d = cap_div_q;
        cap_src_d = cap_src_q;
        clk_en_d  = cfg_clk_enable;
        gate_d    = cfg_gate_enable;
        div_d     = cfg_div_ratio;
        src_d     = cfg_source_sel;
        status_d  = rsp_status;
        rsp_idx_d = rsp_idx;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    cap_idx_d = req_idx;
                    cap_en_d  = req_enable;
                    cap_div_d = req_div;
                    cap_src_d = req_src;
                    rsp_idx_d = req_idx;
                    if (bad_req) begin
                        status_d = ST_BAD;
                        state_d  = RESP;
                    end else begin
                        gate_d  = cfg_gate_enable | req_mask;
                        cnt_d   = 8'(DRAIN_CYCLES);
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = APPLY;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            APPLY: begin
                if (cap_en_q) begin
                    for (int i = 0; i < NUM_CLOCK_OUTPUTS; i++) begin
                        if (tgt_mask[i]) begin
                            div_d[4*i +: 4] = cap_div_q;
                            src_d[2*i +: 2] = cap_src_q;
                        end
                    end
                    clk_en_d = cfg_clk_enable | tgt_mask;
                    cnt_d    = 8'(SETTLE_CYCLES);
                    state_d  = SETTLE;
                end else begin
                    clk_en_d = cfg_clk_enable & ~tgt_mask;
                    status_d = ST_OK;
                    state_d  = RESP;
                end
            end
            SETTLE: begin
                if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'(STABLE_TIMEOUT);
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            CHECK: begin
                if (|(clk_stable & tgt_mask)) begin
                    gate_d   = cfg_gate_enable & ~tgt_mask;
                    status_d = ST_OK;
                    state_d  = RESP;
                end else if (cnt_q <= 8'd1) begin
                    // Never ungate a clock that did not prove stable.
                    cnt_d    = 8'd0;
                    clk_en_d = cfg_clk_enable & ~tgt_mask;
                    status_d = ST_TIMEOUT;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Lock loss overrides whatever the phase decided, including a CHECK success
        // or an APPLY write in the same cycle: target ends disabled and gated.
        if (pll_lost) begin
            div_d    = cfg_div_ratio;
            src_d    = cfg_source_sel;
            clk_en_d = cfg_clk_enable & ~tgt_mask;
            gate_d   = cfg_gate_enable | tgt_mask;
            cnt_d    = 8'd0;
            status_d = ST_PLL;
            state_d  = RESP;
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            cap_idx_q       <= '0;
            cap_en_q        <= 1'b0;
            cap_div_q       <= '0;
            cap_src_q       <= '0;
            cfg_clk_enable  <= '0;
            cfg_gate_enable <= '1;
            cfg_div_ratio   <= '0;
            cfg_source_sel  <= '0;
            rsp_status      <= '0;
            rsp_idx         <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cap_idx_q       <= cap_idx_d;
            cap_en_q        <= cap_en_d;
            cap_div_q       <= cap_div_d;
            cap_src_q       <= cap_src_d;
            cfg_clk_enable  <= clk_en_d;
            cfg_gate_enable <= gate_d;
            cfg_div_ratio   <= div_d;
            cfg_source_sel  <= src_d;
            rsp_status      <= status_d;
            rsp_idx         <= rsp_idx_d;
        end
    end

endmodule

// File: tb/tb_clk_reconfig_sequencer.sv
// Purpose: directed checks of clk_reconfig_sequencer sequencing, status codes and reset.
// Latency: expectations are counted in ref_clk edges from the accepting edge.
// Backpressure: exercises req_ready with pll_locked low and req_valid held high.
module tb_clk_reconfig_sequencer;

    logic        ref_clk = 1'b0;
    logic        rst, pll_locked, req_valid, req_valid6;
    logic        req_enable;
    logic [2:0]  req_idx;
    logic [3:0]  req_div;
    logic [1:0]  req_src;
    logic [7:0]  clk_stable;

    logic        req_ready, rsp_valid, busy;
    logic [7:0]  cfg_clk_enable, cfg_gate_enable;
    logic [31:0] cfg_div_ratio;
    logic [15:0] cfg_source_sel;
    logic [1:0]  rsp_status;
    logic [2:0]  rsp_idx;

    logic        req_ready6, rsp_valid6, busy6;
    logic [5:0]  clk_en6, gate6;
    logic [23:0] div6;
    logic [11:0] src6;
    logic [1:0]  rsp_status6;
    logic [2:0]  rsp_idx6;

    int vectors = 0;
    int miscompares = 0;

    always #5 ref_clk = ~ref_clk;

    clk_reconfig_sequencer u_dut (
        .ref_clk(ref_clk), .rst(rst), .pll_locked(pll_locked),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .req_enable(req_enable), .req_div(req_div), .req_src(req_src),
        .clk_stable(clk_stable), .cfg_clk_enable(cfg_clk_enable),
        .cfg_gate_enable(cfg_gate_enable), .cfg_div_ratio(cfg_div_ratio),
        .cfg_source_sel(cfg_source_sel), .rsp_valid(rsp_valid),
        .rsp_status(rsp_status), .rsp_idx(rsp_idx), .busy(busy)
    );

    clk_reconfig_sequencer #(.NUM_CLOCK_OUTPUTS(6), .IDX_W(3)) u_dut6 (
        .ref_clk(ref_clk), .rst(rst), .pll_locked(pll_locked),
        .req_valid(req_valid6), .req_ready(req_ready6), .req_idx(req_idx),
        .req_enable(req_enable), .req_div(req_div), .req_src(req_src),
        .clk_stable(clk_stable[5:0]), .cfg_clk_enable(clk_en6),
        .cfg_gate_enable(gate6), .cfg_div_ratio(div6),
        .cfg_source_sel(src6), .rsp_valid(rsp_valid6),
        .rsp_status(rsp_status6), .rsp_idx(rsp_idx6), .busy(busy6)
    );

    task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge ref_clk);
            #1;
        end
    endtask

    // Present a request for exactly one edge (the accepting edge 0).
    task automatic issue(input logic [2:0] idx, input logic en, input logic [3:0] div, input logic [1:0] src);
        req_idx    = idx;
        req_enable = en;
        req_div    = div;
        req_src    = src;
        req_valid  = 1'b1;
        tick(1);
        req_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pll_locked = 1'b1; req_valid = 1'b0; req_valid6 = 1'b0;
        req_idx = '0; req_enable = 1'b0; req_div = '0; req_src = '0; clk_stable = '0;
        tick(2);
        chk_vec("rst_gate",  cfg_gate_enable, 8'hFF);
        chk_vec("rst_en",    cfg_clk_enable, 8'h00);
        chk_vec("rst_div",   cfg_div_ratio, 32'h0);
        chk_vec("rst_src",   cfg_source_sel, 16'h0);
        chk_vec("rst_rsp",   {rsp_valid, rsp_status, rsp_idx, busy}, 7'h0);
        chk_vec("rst_ready", req_ready, 1'b1);
        rst = 1'b0;

        // Enable output 2: config after edge 5, ungate + response after edge 22.
        clk_stable = 8'h04;
        issue(3'd2, 1'b1, 4'd4, 2'b01);
        req_div = 4'd9;                  // must not leak into captured settings
        chk_vec("t1_busy", {busy, req_ready}, 2'b10);
        tick(4);
        chk_vec("t1_div_pre", cfg_div_ratio, 32'h0);
        tick(1);
        chk_vec("t1_div", cfg_div_ratio, 32'h0000_0400);
        chk_vec("t1_src", cfg_source_sel, 16'h0010);
        chk_vec("t1_en",  cfg_clk_enable, 8'h04);
        tick(16);
        chk_vec("t1_pre_rsp", {rsp_valid, cfg_gate_enable}, {1'b0, 8'hFF});
        tick(1);
        chk_vec("t1_rsp",  {rsp_valid, rsp_status, rsp_idx}, {1'b1, 2'b00, 3'd2});
        chk_vec("t1_gate", cfg_gate_enable, 8'hFB);
        tick(1);
        chk_vec("t1_done", {rsp_valid, busy}, 2'b00);

        // Enable output 6, then disable it: no settle/check phase.
        clk_stable = 8'h44;
        issue(3'd6, 1'b1, 4'hA, 2'b00);
        tick(22);
        chk_vec("t2_en_rsp", {rsp_valid, rsp_status, cfg_gate_enable, cfg_clk_enable}, {1'b1, 2'b00, 8'hBB, 8'h44});
        tick(1);
        issue(3'd6, 1'b0, 4'd0, 2'b00);
        chk_vec("t2_gate", cfg_gate_enable, 8'hFB);
        tick(4);
        chk_vec("t2_en_pre", {rsp_valid, cfg_clk_enable}, {1'b0, 8'h44});
        tick(1);
        chk_vec("t2_rsp", {rsp_valid, rsp_status, rsp_idx}, {1'b1, 2'b00, 3'd6});
        chk_vec("t2_cfg", {cfg_clk_enable, cfg_gate_enable, cfg_div_ratio}, {8'h04, 8'hFB, 32'h0A00_0400});
        tick(1);
        chk_vec("t2_idle", busy, 1'b0);

        // Output 5 never stabilises: CHECK entered after edge 21, timeout after edge 276.
        clk_stable = 8'h04;
        issue(3'd5, 1'b1, 4'd3, 2'b01);
        tick(5);
        chk_vec("t3_en_on", cfg_clk_enable, 8'h24);
        tick(270);
        chk_vec("t3_pre", rsp_valid, 1'b0);
        tick(1);
        chk_vec("t3_rsp", {rsp_valid, rsp_status, rsp_idx}, {1'b1, 2'b01, 3'd5});
        chk_vec("t3_cfg", {cfg_clk_enable, cfg_gate_enable}, {8'h04, 8'hFB});
        tick(1);

        // Illegal source with enable: immediate status 10, configuration untouched.
        issue(3'd1, 1'b1, 4'd2, 2'b11);
        chk_vec("t4_rsp", {rsp_valid, rsp_status, rsp_idx}, {1'b1, 2'b10, 3'd1});
        chk_vec("t4_cfg", {cfg_clk_enable, cfg_gate_enable, cfg_div_ratio, cfg_source_sel},
                {8'h04, 8'hFB, 32'h0A30_0400, 16'h0410});
        tick(1);

        // Index beyond a 6-output instance.
        chk_vec("t5_ready", req_ready6, 1'b1);
        req_idx = 3'd7; req_enable = 1'b1; req_div = 4'd1; req_src = 2'b01;
        req_valid6 = 1'b1;
        tick(1);
        req_valid6 = 1'b0;
        chk_vec("t5_rsp", {rsp_valid6, rsp_status6, rsp_idx6}, {1'b1, 2'b10, 3'd7});
        chk_vec("t5_cfg", {clk_en6, gate6, div6, src6}, {6'h00, 6'h3F, 24'h0, 12'h0});
        tick(1);
        chk_vec("t5_done", {rsp_valid6, busy6}, 2'b00);

        // PLL loss during SETTLE.
        issue(3'd3, 1'b1, 4'd5, 2'b01);
        tick(5);
        chk_vec("t6_en_on", cfg_clk_enable, 8'h0C);
        tick(3);
        pll_locked = 1'b0;
        tick(1);
        chk_vec("t6_rsp", {rsp_valid, rsp_status, rsp_idx}, {1'b1, 2'b11, 3'd3});
        chk_vec("t6_cfg", {cfg_clk_enable, cfg_gate_enable, req_ready}, {8'h04, 8'hFB, 1'b0});
        tick(1);
        req_idx = 3'd0; req_enable = 1'b1; req_div = 4'd2; req_src = 2'b00;
        req_valid = 1'b1;
        clk_stable = 8'h05;
        tick(3);
        chk_vec("t6_blocked", {busy, req_ready}, 2'b00);

        // Relock with req_valid held: back-to-back requests only from IDLE.
        pll_locked = 1'b1;
        tick(1);
        chk_vec("t7_acc1", busy, 1'b1);
        tick(22);
        chk_vec("t7_rsp1", {rsp_valid, rsp_status, rsp_idx, cfg_gate_enable}, {1'b1, 2'b00, 3'd0, 8'hFA});
        tick(1);
        chk_vec("t7_gap", {busy, req_ready}, 2'b01);
        clk_stable = 8'h04;
        tick(1);
        chk_vec("t7_acc2", busy, 1'b1);
        req_valid = 1'b0;
        tick(22);
        chk_vec("t7_in_check", {busy, rsp_valid}, 2'b10);

        // Reset while in CHECK.
        rst = 1'b1;
        tick(1);
        chk_vec("t8_rst", {rsp_valid, busy, cfg_clk_enable, cfg_gate_enable}, {2'b00, 8'h00, 8'hFF});
        chk_vec("t8_rst_cfg", {cfg_div_ratio, cfg_source_sel, rsp_status, rsp_idx}, 53'h0);
        rst = 1'b0;
        tick(2);
        chk_vec("t8_quiet", {rsp_valid, busy}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
